// File: rtl/demux_sched_if.sv
// Handshake and bus bundle between the demux scheduler and its upstream source / downstream demux.
// Master drives the source-side inputs and per-channel readies; slave is the scheduler.
interface demux_sched_if #(
  parameter int DW = 8
);
  logic          mode;
  logic [7:0]    en_mask;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic [2:0]    in_dest;
  logic          in_ready;
  logic [2:0]    sel;
  logic [DW-1:0] out_data;
  logic [7:0]    out_valid;
  logic [7:0]    out_ready;
  logic          busy;
  logic [7:0]    drop_cnt;

  modport master (
    output mode, en_mask, in_valid, in_data, in_dest, out_ready,
    input  in_ready, sel, out_data, out_valid, busy, drop_cnt
  );

  modport slave (
    input  mode, en_mask, in_valid, in_data, in_dest, out_ready,
    output in_ready, sel, out_data, out_valid, busy, drop_cnt
  );
endinterface

// File: rtl/demux_sched.sv
// Sequencer for a 1:8 demux: takes one upstream word at a time, routes it round-robin or by
// address to one channel, and drops it if the channel stalls for TMO cycles.
module demux_sched #(
  parameter int DW  = 8,
  parameter int TMO = 16
) (
  input logic          clk,
  input logic          rst,
  demux_sched_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ROUTE = 1'b1
  } state_t;

  state_t        state_q;
  logic [2:0]    rr_ptr_q;
  logic [2:0]    sel_q;
  logic [DW-1:0] out_data_q;
  logic [7:0]    out_valid_q;
  logic          busy_q;
  logic [7:0]    drop_cnt_q;
  logic [15:0]   wait_q;
  logic [2:0]    dest_d;
  logic          in_ready_d;
  logic          addr_drop_d;
  logic          tmo_hit_d;

  // First enabled channel strictly after ptr; ptr itself has the lowest priority.
  function automatic logic [2:0] rr_pick(input logic [2:0] ptr, input logic [7:0] mask);
    logic [2:0] pick;
    logic [2:0] idx;
    pick = ptr;
    for (int k = 8; k >= 1; k--) begin
      idx = ptr + 3'(k);
      if (mask[idx]) begin
        pick = idx;
      end
    end
    return pick;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Accept-side decode: readiness, resolved destination, and drop/timeout conditions.
  always_comb begin
    in_ready_d  = (state_q == IDLE) && !rst && (bus.mode || (|bus.en_mask));
    dest_d      = bus.mode ? bus.in_dest : rr_pick(rr_ptr_q, bus.en_mask);
    addr_drop_d = bus.mode && !bus.en_mask[bus.in_dest];
    tmo_hit_d   = (TMO != 0) && (wait_q == 16'(TMO - 1));
  end

  // Main FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= 3'd7;
      sel_q       <= 3'd0;
      out_data_q  <= '0;
      out_valid_q <= 8'h00;
      busy_q      <= 1'b0;
      drop_cnt_q  <= 8'h00;
      wait_q      <= 16'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid && in_ready_d) begin
            out_data_q <= bus.in_data;
            if (addr_drop_d) begin
              drop_cnt_q <= sat_inc(drop_cnt_q);
            end else begin
              sel_q       <= dest_d;
              out_valid_q <= 8'h01 << dest_d;
              busy_q      <= 1'b1;
              wait_q      <= 16'd0;
              state_q     <= ROUTE;
            end
          end
        end
        ROUTE: begin
          // A ready in the timeout cycle still counts as a transfer.
          if (bus.out_ready[sel_q] || tmo_hit_d) begin
            out_valid_q <= 8'h00;
            busy_q      <= 1'b0;
            rr_ptr_q    <= sel_q;
            state_q     <= IDLE;
            if (!bus.out_ready[sel_q]) begin
              drop_cnt_q <= sat_inc(drop_cnt_q);
            end
          end else begin
            wait_q <= wait_q + 16'd1;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 8'h00;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_d;
  assign bus.sel       = sel_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_demux_sched.sv
// Directed bench for demux_sched with TMO=4: reset, round-robin, mask change, addressed drop,
// timeout drop/rescue and reset in ROUTE, all against hand-computed values.
module tb_demux_sched;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  demux_sched_if #(.DW(8)) bus ();

  demux_sched #(.DW(8), .TMO(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer one word, confirm it is accepted and presented on the expected channel next cycle.
  task automatic accept_word(input logic [7:0] data, input logic [2:0] dest, input logic [2:0] exp_sel);
    bus.in_data  = data;
    bus.in_dest  = dest;
    bus.in_valid = 1'b1;
    #1;
    chk("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("out_valid_after_accept", 32'(bus.out_valid), 32'(8'h01 << exp_sel));
    chk("sel_after_accept", 32'(bus.sel), 32'(exp_sel));
    chk("out_data_after_accept", 32'(bus.out_data), 32'(data));
    chk("busy_in_route", 32'(bus.busy), 32'd1);
    chk("in_ready_in_route", 32'(bus.in_ready), 32'd0);
  endtask

  task automatic complete(input logic [7:0] exp_drop);
    tick();
    chk("out_valid_after_done", 32'(bus.out_valid), 32'd0);
    chk("busy_after_done", 32'(bus.busy), 32'd0);
    chk("drop_cnt_after_done", 32'(bus.drop_cnt), 32'(exp_drop));
  endtask

  initial begin
    logic [7:0] chans[4];
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.mode      = 1'b0;
    bus.en_mask   = 8'hFF;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hAA;
    bus.in_dest   = 3'd0;
    bus.out_ready = 8'hFF;

    // Reset held two cycles with in_valid high.
    tick();
    tick();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_drop_cnt", 32'(bus.drop_cnt), 32'd0);
    chk("rst_sel", 32'(bus.sel), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    rst          = 1'b0;
    bus.in_valid = 1'b0;

    // Round-robin, all enabled: 0x10..0x18 go to 0..7 then 0, one word per 2 cycles.
    for (int i = 0; i < 9; i++) begin
      accept_word(8'(8'h10 + i), 3'd0, 3'(i % 8));
      complete(8'd0);
    end

    // Sparse mask 0xA4 from rr_ptr=0: channels 2,5,7,2.
    bus.en_mask = 8'hA4;
    chans[0] = 8'd2; chans[1] = 8'd5; chans[2] = 8'd7; chans[3] = 8'd2;
    for (int i = 0; i < 4; i++) begin
      accept_word(8'(8'h20 + i), 3'd0, chans[i][2:0]);
      complete(8'd0);
    end

    // Mask change while routing does not disturb the held word (channel 5).
    bus.out_ready = 8'h00;
    accept_word(8'h25, 3'd0, 3'd5);
    bus.en_mask = 8'h01;
    tick();
    chk("mask_change_hold_valid", 32'(bus.out_valid), 32'h20);
    chk("mask_change_hold_sel", 32'(bus.sel), 32'd5);
    bus.out_ready = 8'hFF;
    complete(8'd0);
    accept_word(8'h26, 3'd0, 3'd0);
    complete(8'd0);

    // Addressed mode: disabled destination is dropped without routing.
    bus.mode    = 1'b1;
    bus.en_mask = 8'h0F;
    bus.in_data = 8'h55;
    bus.in_dest = 3'd5;
    bus.in_valid = 1'b1;
    #1;
    chk("addr_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("addr_drop_cnt", 32'(bus.drop_cnt), 32'd1);
    chk("addr_drop_out_valid", 32'(bus.out_valid), 32'd0);
    chk("addr_drop_busy", 32'(bus.busy), 32'd0);
    chk("addr_drop_in_ready", 32'(bus.in_ready), 32'd1);
    accept_word(8'h33, 3'd3, 3'd3);
    complete(8'd1);

    // Timeout: rr_ptr=3 so channel 4; valid held exactly 4 cycles, then dropped.
    bus.mode      = 1'b0;
    bus.en_mask   = 8'hFF;
    bus.out_ready = 8'h00;
    accept_word(8'h44, 3'd0, 3'd4);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("tmo_stall_valid", 32'(bus.out_valid), 32'h10);
    end
    complete(8'd2);

    // Channel 5 with every other ready high; its own ready arrives on the 4th stall cycle.
    bus.out_ready = 8'hDF;
    accept_word(8'h45, 3'd0, 3'd5);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rescue_stall_valid", 32'(bus.out_valid), 32'h20);
    end
    bus.out_ready = 8'h20;
    complete(8'd2);

    // Reset during ROUTE abandons the word without counting a drop.
    bus.out_ready = 8'h00;
    accept_word(8'h46, 3'd0, 3'd6);
    tick();
    chk("pre_rst_valid", 32'(bus.out_valid), 32'h40);
    rst = 1'b1;
    tick();
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_drop_cnt", 32'(bus.drop_cnt), 32'd0);
    chk("mid_rst_sel", 32'(bus.sel), 32'd0);
    rst = 1'b0;

    // Round-robin with nothing enabled never becomes ready.
    bus.en_mask  = 8'h00;
    bus.in_valid = 1'b1;
    tick();
    chk("no_enable_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    chk("no_enable_busy", 32'(bus.busy), 32'd0);
    bus.in_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
